// File: rtl/dcache_pkg.sv
// Shared types, address-split widths and address helpers for the data cache.
// The cache geometry is fixed here; dcache_ctrl's parameters default to these values.
package dcache_pkg;

  localparam int DC_NUM_LINES      = 16;
  localparam int DC_WORDS_PER_LINE = 4;
  localparam int DC_ADDR_W         = 32;

  localparam int WORD_SEL_W = $clog2(DC_WORDS_PER_LINE);
  localparam int OFFSET_W   = WORD_SEL_W + 2;
  localparam int INDEX_W    = $clog2(DC_NUM_LINES);
  localparam int TAG_W      = DC_ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL     = 2'd1,
    WRITE_THRU = 2'd2
  } state_e;

  function automatic logic [INDEX_W-1:0] get_index(input logic [DC_ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [DC_ADDR_W-1:0] addr);
    return addr[DC_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] get_word(input logic [DC_ADDR_W-1:0] addr);
    return addr[2 +: WORD_SEL_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational lookup, byte-enabled word write,
// tag+valid write; reset clears every valid bit.
module dcache_array #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 26,
  localparam int IW            = $clog2(NUM_LINES),
  localparam int WW            = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IW-1:0]    rd_index,
  input  logic [WW-1:0]    rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_index,
  input  logic [WW-1:0]    wr_word,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             tag_we,
  input  logic [IW-1:0]    tag_index,
  input  logic             tag_valid,
  input  logic [TAG_W-1:0] tag_wdata
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];

  // Lookup is purely combinational so a hit resolves in the request cycle
  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_word}];

  // Next valid vector: a tag write sets or clears the line's valid bit
  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[tag_index] = tag_valid;
  end

  // Valid bits are the only storage that needs clearing on reset
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag storage; contents are meaningless while the line is invalid
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[tag_index] <= tag_wdata;
  end

  // Byte-lane merge of the written word
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) data_mem[{wr_index, wr_word}][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = DC_NUM_LINES,
  parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE,
  parameter int ADDR_W         = DC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [31:0]       cpu_rdata,
  output logic              cache_hit,
  output logic              cache_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam logic [WORD_SEL_W-1:0] LAST_WORD = WORD_SEL_W'(WORDS_PER_LINE - 1);

  state_e                     state_q, state_d;
  logic [ADDR_W-OFFSET_W-1:0] line_q, line_d;    // refill line base (upper bits)
  logic [WORD_SEL_W-1:0]      cnt_q, cnt_d;      // refill word counter
  logic [ADDR_W-3:0]          wa_q, wa_d;        // write-through word address
  logic [31:0]                wd_q, wd_d;
  logic [3:0]                 be_q, be_d;
  logic [31:0]                hit_cnt_q, hit_cnt_d;
  logic [31:0]                miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0]    lk_index, rf_index, arr_wr_index, arr_tag_index;
  logic [TAG_W-1:0]      lk_tag, rf_tag, arr_rd_tag, arr_tag_wdata;
  logic [WORD_SEL_W-1:0] lk_word, arr_wr_word;
  logic [ADDR_W-1:0]     rf_addr;
  logic                  arr_rd_valid, lk_hit;
  logic                  arr_wr_en, arr_tag_we, arr_tag_valid;
  logic [31:0]           arr_wr_data;
  logic [3:0]            arr_wr_be;

  assign lk_index = get_index(cpu_addr);
  assign lk_tag   = get_tag(cpu_addr);
  assign lk_word  = get_word(cpu_addr);
  assign rf_addr  = {line_q, {OFFSET_W{1'b0}}};
  assign rf_index = get_index(rf_addr);
  assign rf_tag   = get_tag(rf_addr);
  assign lk_hit   = arr_rd_valid && (arr_rd_tag == lk_tag);

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (lk_index),
    .rd_word   (lk_word),
    .rd_valid  (arr_rd_valid),
    .rd_tag    (arr_rd_tag),
    .rd_data   (cpu_rdata),
    .wr_en     (arr_wr_en),
    .wr_index  (arr_wr_index),
    .wr_word   (arr_wr_word),
    .wr_data   (arr_wr_data),
    .wr_be     (arr_wr_be),
    .tag_we    (arr_tag_we),
    .tag_index (arr_tag_index),
    .tag_valid (arr_tag_valid),
    .tag_wdata (arr_tag_wdata)
  );

  // Next-state, array write port and bus outputs for the three-state controller
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    wa_d          = wa_q;
    wd_d          = wd_q;
    be_d          = be_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    cache_hit     = 1'b0;
    cache_stall   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = '0;
    arr_wr_en     = 1'b0;
    arr_wr_index  = lk_index;
    arr_wr_word   = lk_word;
    arr_wr_data   = cpu_wdata;
    arr_wr_be     = cpu_be;
    arr_tag_we    = 1'b0;
    arr_tag_index = lk_index;
    arr_tag_valid = 1'b0;
    arr_tag_wdata = lk_tag;
    unique case (state_q)
      IDLE: begin
        if (cpu_write) begin
          // Store wins over a simultaneous load; update the copy only on a hit
          cache_stall = 1'b1;
          arr_wr_en   = lk_hit;
          wa_d        = cpu_addr[ADDR_W-1:2];
          wd_d        = cpu_wdata;
          be_d        = cpu_be;
          state_d     = WRITE_THRU;
        end else if (cpu_read) begin
          if (lk_hit) begin
            cache_hit = 1'b1;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            // Invalidate the victim now so a half-filled line is never hit
            cache_stall = 1'b1;
            miss_cnt_d  = miss_cnt_q + 32'd1;
            line_d      = cpu_addr[ADDR_W-1:OFFSET_W];
            cnt_d       = '0;
            arr_tag_we  = 1'b1;
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req       = 1'b1;
        cache_stall   = 1'b1;
        mem_addr      = {line_q, cnt_q, 2'b00};
        arr_wr_index  = rf_index;
        arr_wr_word   = cnt_q;
        arr_wr_data   = mem_rdata;
        arr_wr_be     = 4'hF;
        arr_tag_index = rf_index;
        arr_tag_wdata = rf_tag;
        if (mem_ready) begin
          arr_wr_en = 1'b1;
          cnt_d     = cnt_q + WORD_SEL_W'(1);
          if (cnt_q == LAST_WORD) begin
            arr_tag_we    = 1'b1;
            arr_tag_valid = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      WRITE_THRU: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {wa_q, 2'b00};
        mem_wdata   = wd_q;
        mem_be      = be_q;
        cache_stall = ~mem_ready;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latches and counters; reset aborts any bus transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      cnt_q      <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      be_q       <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      be_q       <= be_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage of the pipelined processor and the data memory.
- Serves lw/lh/lb/sw/sh/sb accesses from MEM.
- Drives `cache_hit` and `cache_stall`; the hazard unit ORs `cache_stall` into the pipeline stall.
- Refills a whole line from memory over a simple req/ready handshake.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_read  in  1  load request from MEM stage.
- cpu_write  in  1  store request from MEM stage.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_be  in  4  byte enables for stores.
- cpu_rdata  out  32  load word (full word; MEM stage extracts bytes/halves).
- cache_hit  out  1  current read request hits.
- cache_stall  out  1  pipeline must hold.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  32  write data.
- mem_be  out  4  write byte enables.
- mem_rdata  in  32  read data, valid when mem_ready is high.
- mem_ready  in  1  completes the current request this cycle.
- hit_count  out  32  read hits since reset.
- miss_count  out  32  read misses since reset.

Behaviour:
- Address split:
  - [1:0] byte offset, ignored for lookup.
  - [log2(WPL)+1:2] word.
  - next log2(NUM_LINES) bits are the index.
  - remaining high bits are the tag.
- Storage per line: valid bit, tag, WORDS_PER_LINE words.
- Reset (one edge):
  - all valid bits = 0, FSM = IDLE, counters = 0.
  - all outputs 0 except cpu_rdata, which follows the combinational array read.
  - Reset mid-REFILL or mid-WRITE_THRU aborts the transaction; the line stays invalid; mem_req drops the next cycle.
- FSM states: IDLE, REFILL, WRITE_THRU.
- IDLE:
  - Read hit (valid && tag match): cpu_rdata = line word combinationally, cache_hit = 1, cache_stall = 0; hit_count++ at the edge.
  - Read miss: cache_stall = 1 combinationally, cache_hit = 0; miss_count++. Latch line base address, word counter = 0, go to REFILL.
  - Write: cache_stall = 1. If hit, merge cpu_wdata into the cached word per cpu_be at the edge. Latch addr/wdata/be, go to WRITE_THRU. Write miss does not allocate.
  - cpu_read and cpu_write both high: treated as write.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = base + 4*counter. cache_stall = 1.
  - On mem_ready: store mem_rdata into word[counter], counter++.
  - When the last word is accepted: write tag, set valid, go to IDLE.
  - The held request then hits the cycle after return; stall drops that cycle.
- WRITE_THRU:
  - mem_req = 1, mem_we = 1, mem_addr/mem_wdata/mem_be from latches.
  - cache_stall = ~mem_ready; on mem_ready go to IDLE.
- mem_req may stay high across consecutive refill words. mem_addr is stable while mem_req is high and mem_ready is low.
- Counters wrap at 2^32. A held miss counts once, not per stall cycle; its post-refill hit is counted as a hit.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE/REFILL/WRITE_THRU).
  - derived widths: OFFSET_W, INDEX_W, TAG_W.
  - helper functions get_index, get_tag, get_word.
- One sub-module, dcache_array: valid/tag/data storage with combinational read, synchronous byte-enabled word write, synchronous tag/valid write, reset clear of valid bits.
- The FSM and counters live in dcache_ctrl.

Test Plan:
- Reset, then lw 0x100 → miss, stall = 1.
  - Memory (ready every cycle) returns 0x11, 0x22, 0x33, 0x44 for 0x100–0x10C.
  - Stall held 5 cycles; cpu_rdata = 0x11, cache_hit = 1 on return; miss_count = 1, hit_count = 1.
- After the above, lw 0x108 → same-cycle hit, cpu_rdata = 0x33, stall = 0.
- sw 0xDEADBEEF to 0x104 (hit, be = 4'b1111), mem_ready delayed 3 cycles.
  - stall high until the mem_ready cycle; mem_we = 1, mem_addr = 0x104.
  - Subsequent lw 0x104 hits with 0xDEADBEEF.
- sb 0xAA to 0x10D (be = 4'b0010) on a hit line holding 0x44 at 0x10C → cached word = 0x0000AA44.
- sw to 0x500 (miss) → one memory write, no allocate; following lw 0x500 misses and refills.
- Conflict and abort:
  - lw 0x100 then lw 0x200 (same index, different tag) → second access evicts; lw 0x100 misses again.
  - Assert reset during the 2nd refill word → all valid bits cleared, FSM IDLE, lw 0x200 misses again.
